// File: rtl/branch_redirect_unit.sv
// Fetch PC owner: sequential fetch, taken-branch/jump redirect with registered
// IF/ID and ID/EX flush pulses, stall/back-pressure arbitration, redirect count.
module branch_redirect_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic [5:0]      ex_aluSelect,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            imem_ready,
    output logic [XLEN-1:0] pc_out,
    output logic            fetch_req,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            misalign_err,
    output logic [15:0]     redirect_count
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    state_t     state;
    logic [2:0] flush_cnt;
    logic       eligible;
    logic       taken_ok;
    logic       redirect;
    logic       misalign;

    // JAL..BGEU occupy the contiguous code range 3..10.
    always_comb begin
        eligible = (ex_aluSelect >= 6'd3) && (ex_aluSelect <= 6'd10);
        taken_ok = (state == RUN) && ex_valid && branch_taken && eligible;
        redirect = taken_ok && (branch_target[1:0] == 2'b00);
        misalign = taken_ok && (branch_target[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= RUN;
            flush_cnt      <= '0;
            pc_out         <= RESET_PC;
            fetch_req      <= 1'b0;
            flush_ifid     <= 1'b0;
            flush_idex     <= 1'b0;
            misalign_err   <= 1'b0;
            redirect_count <= '0;
        end else begin
            fetch_req    <= 1'b1;
            misalign_err <= misalign;
            if (redirect) begin
                // Redirect beats stall and back-pressure; the flush kills the in-flight fetch.
                pc_out         <= branch_target;
                redirect_count <= redirect_count + 16'd1;
                state          <= FLUSH;
                flush_cnt      <= FLUSH_INIT;
                flush_ifid     <= 1'b1;
                flush_idex     <= 1'b1;
            end else begin
                if (!stall && fetch_req && imem_ready)
                    pc_out <= pc_out + XLEN'(4);
                if (state == FLUSH) begin
                    if (flush_cnt <= 3'd1) begin
                        state      <= RUN;
                        flush_cnt  <= '0;
                        flush_ifid <= 1'b0;
                        flush_idex <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Randomized bench for branch_redirect_unit against a cycle-level reference model,
// with directed scenarios and literal anchors on the model.
module tb_branch_redirect_unit;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        ex_valid;
    logic [5:0]  ex_aluSelect;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_ready;
    logic [31:0] pc_out;
    logic        fetch_req;
    logic        flush_ifid;
    logic        flush_idex;
    logic        misalign_err;
    logic [15:0] redirect_count;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [31:0] m_pc;
    logic        m_fetch;
    int          m_flush_left;
    logic        m_mis;
    logic [15:0] m_cnt;

    branch_redirect_unit #(.XLEN(32), .RESET_PC(32'h0), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .ex_valid(ex_valid),
        .ex_aluSelect(ex_aluSelect), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_ready(imem_ready),
        .pc_out(pc_out), .fetch_req(fetch_req), .flush_ifid(flush_ifid),
        .flush_idex(flush_idex), .misalign_err(misalign_err),
        .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_fetch = 1'b0; m_flush_left = 0; m_mis = 1'b0; m_cnt = 16'h0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_next();
        bit hit, redir;
        hit   = ex_valid && branch_taken && (ex_aluSelect >= 6'd3) && (ex_aluSelect <= 6'd10)
                && (m_flush_left == 0);
        redir = hit && (branch_target[1:0] == 2'b00);
        m_mis = hit && (branch_target[1:0] != 2'b00);
        if (redir) m_pc = branch_target;
        else if (!stall && m_fetch && imem_ready) m_pc = m_pc + 32'd4;
        if (redir) begin
            m_cnt = m_cnt + 16'd1;
            m_flush_left = FC;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end
        m_fetch = 1'b1;
    endtask

    task automatic compare();
        chk("pc_out", pc_out, m_pc);
        chk("fetch_req", 32'(fetch_req), 32'(m_fetch));
        chk("flush_ifid", 32'(flush_ifid), 32'(m_flush_left > 0));
        chk("flush_idex", 32'(flush_idex), 32'(m_flush_left > 0));
        chk("misalign_err", 32'(misalign_err), 32'(m_mis));
        chk("redirect_count", 32'(redirect_count), 32'(m_cnt));
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic set_ex(input logic v, input logic [5:0] sel, input logic tk, input logic [31:0] tgt);
        ex_valid = v; ex_aluSelect = sel; branch_taken = tk; branch_target = tgt;
    endtask

    task automatic async_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        compare();
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; imem_ready = 1'b1;
        set_ex(1'b0, 6'd0, 1'b0, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare();
        reset_n = 1'b1;

        // sequential fetch from reset
        repeat (4) step();
        chk("lit_seq_pc", pc_out, 32'hC);
        step();
        chk("lit_pc_10", pc_out, 32'h10);

        // taken BEQ to 0x80
        set_ex(1'b1, 6'b000101, 1'b1, 32'h80);
        step();
        set_ex(1'b0, 6'd0, 1'b0, 32'h0);
        chk("lit_beq_pc", pc_out, 32'h80);
        chk("lit_beq_flush", 32'(flush_ifid), 32'd1);
        chk("lit_beq_cnt", 32'(redirect_count), 32'd1);
        step();
        chk("lit_pc_84", pc_out, 32'h84);
        step();
        chk("lit_pc_88", pc_out, 32'h88);
        chk("lit_flush_done", 32'(flush_idex), 32'd0);

        // JALR wins over stall and back-pressure; BNE inside flush ignored
        stall = 1'b1; imem_ready = 1'b0;
        set_ex(1'b1, 6'b000100, 1'b1, 32'h200);
        step();
        chk("lit_jalr_pc", pc_out, 32'h200);
        stall = 1'b0; imem_ready = 1'b1;
        set_ex(1'b1, 6'b000110, 1'b1, 32'h300);
        step();
        set_ex(1'b0, 6'd0, 1'b0, 32'h0);
        step();
        chk("lit_bne_ignored_cnt", 32'(redirect_count), 32'd2);
        chk("lit_bne_ignored_pc", pc_out, 32'h208);

        // non-eligible code and invalid slot
        set_ex(1'b1, 6'b111111, 1'b1, 32'h40);
        step();
        set_ex(1'b0, 6'b000101, 1'b1, 32'h40);
        step();
        set_ex(1'b0, 6'd0, 1'b0, 32'h0);
        chk("lit_no_redirect_pc", pc_out, 32'h210);

        // misaligned BLT target
        set_ex(1'b1, 6'b000111, 1'b1, 32'h102);
        step();
        set_ex(1'b0, 6'd0, 1'b0, 32'h0);
        chk("lit_misalign", 32'(misalign_err), 32'd1);
        chk("lit_misalign_pc", pc_out, 32'h214);
        step();
        chk("lit_misalign_pulse_end", 32'(misalign_err), 32'd0);

        // back-pressure holds
        imem_ready = 1'b0;
        repeat (3) step();
        imem_ready = 1'b1;

        // wrap at top of address space
        set_ex(1'b1, 6'b000011, 1'b1, 32'hFFFFFFF8);
        step();
        set_ex(1'b0, 6'd0, 1'b0, 32'h0);
        step();
        step();
        chk("lit_wrap", pc_out, 32'h0);

        // reset mid-flush, no clock edge
        set_ex(1'b1, 6'b001010, 1'b1, 32'h500);
        step();
        set_ex(1'b0, 6'd0, 1'b0, 32'h0);
        async_reset();
        chk("lit_reset_flush", 32'(flush_ifid), 32'd0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            stall      = ($urandom_range(0, 99) < 20);
            imem_ready = ($urandom_range(0, 99) < 75);
            ex_valid   = ($urandom_range(0, 99) < 70);
            ex_aluSelect = ($urandom_range(0, 9) == 0) ? 6'h3F : 6'($urandom_range(0, 13));
            branch_taken = $urandom_range(0, 1);
            branch_target = $urandom;
            if ($urandom_range(0, 99) < 85) branch_target[1:0] = 2'b00;
            step();
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Consumes the EX-stage branch comparator outcome (branch_taken, aluSelect) plus the computed target.
- Owns the fetch PC register and issues sequential instruction fetches.
- On a taken branch or jump: redirects the PC and drives registered flush pulses into the IF/ID and ID/EX pipeline registers.
- Also arbitrates between hazard stalls and instruction-memory back-pressure, and counts redirects.

Parameters:
- XLEN, 32, datapath/PC width.
- RESET_PC, 32'h00000000, PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles flush outputs stay high after a redirect (legal range 1..7).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- stall  input  1  hazard-unit stall request; holds the PC.
- ex_valid  input  1  EX-stage instruction is valid (not a bubble).
- ex_aluSelect  input  6  EX-stage operation code.
- branch_taken  input  1  comparator result from the EX stage.
- branch_target  input  XLEN  computed branch/jump target.
- imem_ready  input  1  instruction memory accepts the current fetch this cycle.
- pc_out  output  XLEN  current fetch address.
- fetch_req  output  1  fetch request to instruction memory.
- flush_ifid  output  1  squash the IF/ID register.
- flush_idex  output  1  squash the ID/EX register.
- misalign_err  output  1  one-cycle pulse when a taken target is misaligned.
- redirect_count  output  16  number of redirects taken; wraps modulo 2^16.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - pc_out=RESET_PC; fetch_req=0; flush_ifid=flush_idex=0; misalign_err=0; redirect_count=0; state=RUN; flush counter=0.
  - fetch_req rises on the first clk edge after reset_n deasserts.
  - Reset mid-flush aborts the flush immediately.
- States:
  - RUN: normal operation.
  - FLUSH: a flush counter loaded with FLUSH_CYCLES decrements every cycle; returns to RUN when the counter reaches 1.
- Redirect-eligible codes: ex_aluSelect in 6'b000011..6'b001010 (JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU).
  - Any other code, including 6'b111111, never redirects, regardless of branch_taken.
- redirect condition (RUN only) = ex_valid & branch_taken & eligible code & branch_target[1:0]==2'b00.
  - Effect: pc_out <= branch_target; redirect_count += 1; enter FLUSH.
  - flush_ifid and flush_idex are high for exactly FLUSH_CYCLES cycles, starting the cycle after the redirect edge.
- Misaligned target (eligible, taken, valid, target[1:0]!=0, RUN):
  - No redirect and no flush; misalign_err high for exactly one cycle.
  - PC follows normal stall/ready rules.
- PC update priority, highest first: reset > redirect > stall > imem_ready.
  - redirect: as above.
  - stall=1: pc_out holds.
  - fetch_req & imem_ready: pc_out <= pc_out + 4, truncated to XLEN, so 32'hFFFFFFFC wraps to 0.
  - Otherwise: pc_out holds.
- Redirect beats a simultaneous stall and a simultaneous imem_ready=0; the in-flight fetch is discarded by the flush.
- In FLUSH:
  - ex inputs are ignored (no redirect, no misalign_err, no count).
  - PC still advances from the target under stall/ready rules.
- fetch_req stays 1 in both states after reset release.
- Latency: redirect decision to new pc_out is one clock edge; flush outputs are registered (no combinational path from inputs).
- Outputs change only on clk edges, except the asynchronous reset.

Test Plan:
- Reset then 3 cycles with imem_ready=1, stall=0 -> pc_out 0x0, 0x4, 0x8, 0xC; fetch_req=1 from the first edge; flushes 0.
- pc=0x10, ex_valid=1, aluSelect=6'b000101 (BEQ), branch_taken=1, target=0x80 -> next pc_out=0x80; flush_ifid=flush_idex=1 for exactly 2 cycles; redirect_count=1; pc then 0x84, 0x88.
- Same cycle: stall=1, imem_ready=0, aluSelect=6'b000100 (JALR) taken, target=0x200 -> pc_out=0x200 (redirect wins); a second taken BNE to 0x300 during the flush window is ignored and redirect_count increments once.
- aluSelect=6'b111111, branch_taken=1, ex_valid=1, target=0x40 -> no redirect, no flush, PC sequential; ex_valid=0 with BEQ taken -> no redirect.
- Taken BLT with target=0x102 -> misalign_err one-cycle pulse; pc_out unchanged by the target; no flush; count unchanged.
- imem_ready=0 for 3 cycles -> pc_out holds; pc=0xFFFFFFFC with ready -> 0x0; reset_n low during FLUSH -> all outputs at reset values immediately, with no clock edge.
